// File: rtl/if_unit.sv
// if_unit: instruction fetch stage with PC register, IF/ID pipeline register
// and a four-state fetch controller (RUN, STALL, WAIT_TGT, HALT).
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   data_hazard         ID-stage RAW stall request (freeze fetch and IF/ID)
//   PC_hazard           ID-stage control-flow stall (inject bubbles)
//   redirect            control transfer resolved this cycle
//   redirect_pc [15:0]  new fetch address when redirect=1
//   imem_addr   [15:0]  instruction memory address (the PC register)
//   imem_rdata  [15:0]  combinational instruction read of imem_addr
//   instr_out   [15:0]  IF/ID instruction
//   PC_out      [15:0]  IF/ID address of instr_out plus one
//   valid_out           IF/ID holds a real fetched instruction
//   PC_update           one-cycle pulse after an accepted redirect
//   halted              fetch stopped on a HLT instruction
module if_unit #(
    parameter logic [15:0] NOP_INSTR  = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_hazard,
    input  logic        PC_hazard,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic [15:0] PC_out,
    output logic        valid_out,
    output logic        PC_update,
    output logic        halted
);

    typedef enum logic [1:0] {
        RUN,
        STALL,
        WAIT_TGT,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcout_q, pcout_d;
    logic        valid_q, valid_d;
    logic        upd_q, upd_d;

    logic [15:0] pc_inc;
    logic        is_hlt;

    // Wraps naturally from 16'hFFFF to 16'h0000.
    assign pc_inc = pc_q + 16'd1;
    assign is_hlt = (imem_rdata[15:12] == HLT_OPCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcout_q <= 16'h0000;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
        end
    end

    // Priority: redirect > PC_hazard > data_hazard > normal fetch.
    // HALT ignores everything; only reset leaves it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        valid_d = valid_q;
        upd_d   = 1'b0;

        if (state_q == HALT) begin
            state_d = HALT;
        end else if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            upd_d   = 1'b1;
            state_d = RUN;
        end else if (PC_hazard || state_q == WAIT_TGT) begin
            // Target still unresolved: keep PC, feed bubbles.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = WAIT_TGT;
        end else if (data_hazard) begin
            // Freeze PC and IF/ID; a HLT under the stall is not latched.
            state_d = STALL;
        end else if (is_hlt) begin
            // HLT enters IF/ID as a real instruction, PC stops on it.
            instr_d = imem_rdata;
            pcout_d = pc_inc;
            valid_d = 1'b1;
            state_d = HALT;
        end else begin
            pc_d    = pc_inc;
            instr_d = imem_rdata;
            pcout_d = pc_inc;
            valid_d = 1'b1;
            state_d = RUN;
        end
    end

    assign imem_addr = pc_q;
    assign instr_out = instr_q;
    assign PC_out    = pcout_q;
    assign valid_out = valid_q;
    assign PC_update = upd_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_if_unit.sv
// Directed testbench for if_unit: sequential fetch, stalls, bubbles,
// redirects, halt, PC wrap and asynchronous reset.
module tb_if_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_hazard;
    logic        PC_hazard;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [15:0] PC_out;
    logic        valid_out;
    logic        PC_update;
    logic        halted;

    logic [15:0] mem [0:255];

    int checks = 0;
    int failures = 0;

    if_unit dut (
        .clk         (clk),
        .rst         (rst),
        .data_hazard (data_hazard),
        .PC_hazard   (PC_hazard),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .PC_out      (PC_out),
        .valid_out   (valid_out),
        .PC_update   (PC_update),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:0]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_hazard = 1'b0;
        PC_hazard = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        #3;
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL rst_pc got=%h exp=0000", imem_addr); end
        checks++; if (instr_out !== 16'h0000) begin failures++; $display("FAIL rst_instr got=%h exp=0000", instr_out); end
        checks++; if (PC_out !== 16'h0000) begin failures++; $display("FAIL rst_pcout got=%h exp=0000", PC_out); end
        checks++; if ({valid_out, PC_update, halted} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {valid_out, PC_update, halted}); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_seq_fetch();
        logic [15:0] exp_i [0:3];
        exp_i[0] = 16'h1123; exp_i[1] = 16'h1124;
        exp_i[2] = 16'h1125; exp_i[3] = 16'h1126;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (instr_out !== exp_i[i]) begin failures++; $display("FAIL seq_instr%0d got=%h exp=%h", i, instr_out, exp_i[i]); end
            checks++; if (PC_out !== 16'(i + 1)) begin failures++; $display("FAIL seq_pcout%0d got=%h exp=%h", i, PC_out, 16'(i + 1)); end
            checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b exp=1", i, valid_out); end
        end
        checks++; if (imem_addr !== 16'h0004) begin failures++; $display("FAIL seq_pc got=%h exp=0004", imem_addr); end
    endtask

    task automatic test_data_hazard();
        step();
        checks++; if (imem_addr !== 16'h0005) begin failures++; $display("FAIL dh_setup got=%h exp=0005", imem_addr); end
        data_hazard = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (imem_addr !== 16'h0005) begin failures++; $display("FAIL dh_pc%0d got=%h exp=0005", i, imem_addr); end
            checks++; if (instr_out !== 16'h2004 || PC_out !== 16'h0005) begin failures++; $display("FAIL dh_ifid%0d got=%h/%h exp=2004/0005", i, instr_out, PC_out); end
        end
        data_hazard = 1'b0;
        step();
        checks++; if (instr_out !== 16'h2005 || PC_out !== 16'h0006) begin failures++; $display("FAIL dh_resume got=%h/%h exp=2005/0006", instr_out, PC_out); end
        checks++; if (imem_addr !== 16'h0006 || valid_out !== 1'b1) begin failures++; $display("FAIL dh_resume_pc got=%h/%b exp=0006/1", imem_addr, valid_out); end
    endtask

    task automatic test_pc_hazard();
        step();
        step();
        checks++; if (imem_addr !== 16'h0008) begin failures++; $display("FAIL pch_setup got=%h exp=0008", imem_addr); end
        PC_hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            PC_hazard = 1'b0;
            checks++; if (instr_out !== 16'h0000 || valid_out !== 1'b0) begin failures++; $display("FAIL pch_bubble%0d got=%h/%b exp=0000/0", i, instr_out, valid_out); end
            checks++; if (imem_addr !== 16'h0008 || PC_update !== 1'b0) begin failures++; $display("FAIL pch_hold%0d got=%h/%b exp=0008/0", i, imem_addr, PC_update); end
        end
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        checks++; if (imem_addr !== 16'h0040 || PC_update !== 1'b1 || valid_out !== 1'b0) begin failures++; $display("FAIL pch_redir got=%h/%b/%b exp=0040/1/0", imem_addr, PC_update, valid_out); end
        step();
        checks++; if (PC_update !== 1'b0) begin failures++; $display("FAIL pch_pulse got=%b exp=0", PC_update); end
        checks++; if (instr_out !== 16'h2040 || PC_out !== 16'h0041 || valid_out !== 1'b1) begin failures++; $display("FAIL pch_tgt got=%h/%h/%b exp=2040/0041/1", instr_out, PC_out, valid_out); end
    endtask

    task automatic test_redirect_vs_stall();
        redirect = 1'b1;
        data_hazard = 1'b1;
        redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        data_hazard = 1'b0;
        checks++; if (imem_addr !== 16'h0010 || PC_update !== 1'b1) begin failures++; $display("FAIL rds_take got=%h/%b exp=0010/1", imem_addr, PC_update); end
        checks++; if (valid_out !== 1'b0 || instr_out !== 16'h0000) begin failures++; $display("FAIL rds_nop got=%b/%h exp=0/0000", valid_out, instr_out); end
        step();
        checks++; if (instr_out !== 16'h2010 || PC_out !== 16'h0011 || PC_update !== 1'b0) begin failures++; $display("FAIL rds_next got=%h/%h/%b exp=2010/0011/0", instr_out, PC_out, PC_update); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        step();
        checks++; if (instr_out !== 16'h20FF || PC_out !== 16'h0000) begin failures++; $display("FAIL wrap_ifid got=%h/%h exp=20FF/0000", instr_out, PC_out); end
        checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=0000", imem_addr); end
        step();
        checks++; if (instr_out !== 16'h1123 || PC_out !== 16'h0001) begin failures++; $display("FAIL wrap_next got=%h/%h exp=1123/0001", instr_out, PC_out); end
    endtask

    task automatic test_halt();
        mem[3] = 16'hF000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        checks++; if (imem_addr !== 16'h0003) begin failures++; $display("FAIL hlt_setup got=%h exp=0003", imem_addr); end
        data_hazard = 1'b1;
        step();
        data_hazard = 1'b0;
        checks++; if (halted !== 1'b0 || instr_out !== 16'h1125) begin failures++; $display("FAIL hlt_stall got=%b/%h exp=0/1125", halted, instr_out); end
        step();
        checks++; if (instr_out !== 16'hF000 || PC_out !== 16'h0004 || valid_out !== 1'b1) begin failures++; $display("FAIL hlt_latch got=%h/%h/%b exp=F000/0004/1", instr_out, PC_out, valid_out); end
        checks++; if (halted !== 1'b1 || imem_addr !== 16'h0003) begin failures++; $display("FAIL hlt_state got=%b/%h exp=1/0003", halted, imem_addr); end
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        step();
        checks++; if (imem_addr !== 16'h0003 || PC_update !== 1'b0 || halted !== 1'b1) begin failures++; $display("FAIL hlt_ignore got=%h/%b/%b exp=0003/0/1", imem_addr, PC_update, halted); end
        checks++; if (instr_out !== 16'hF000) begin failures++; $display("FAIL hlt_hold got=%h exp=F000", instr_out); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (imem_addr !== 16'h0000 || halted !== 1'b0) begin failures++; $display("FAIL hlt_rst got=%h/%b exp=0000/0", imem_addr, halted); end
        checks++; if (instr_out !== 16'h0000 || valid_out !== 1'b0) begin failures++; $display("FAIL hlt_rst_ifid got=%h/%b exp=0000/0", instr_out, valid_out); end
        step();
        rst = 1'b0;
        step();
        checks++; if (instr_out !== 16'h1123 || PC_out !== 16'h0001) begin failures++; $display("FAIL hlt_refetch got=%h/%h exp=1123/0001", instr_out, PC_out); end
    endtask

    task automatic test_reset_in_wait();
        PC_hazard = 1'b1;
        step();
        PC_hazard = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (imem_addr !== 16'h0000 || valid_out !== 1'b0 || PC_out !== 16'h0000) begin failures++; $display("FAIL wrst got=%h/%b/%h exp=0000/0/0000", imem_addr, valid_out, PC_out); end
        step();
        rst = 1'b0;
        step();
        checks++; if (instr_out !== 16'h1123 || valid_out !== 1'b1) begin failures++; $display("FAIL wrst_fetch got=%h/%b exp=1123/1", instr_out, valid_out); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h2000 + 16'(i);
        mem[0] = 16'h1123;
        mem[1] = 16'h1124;
        mem[2] = 16'h1125;
        mem[3] = 16'h1126;
        test_reset();
        test_seq_fetch();
        test_data_hazard();
        test_pc_hazard();
        test_redirect_vs_stall();
        test_wrap();
        test_halt();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
